// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl
//
// Detects load-use hazards in decode. A 3-bit down-counter per GP register,
// and per AR register when LOAD_HAZARD_AR_EN is defined, records loads whose
// data has not reached a forwarding path yet. While the decoded instruction
// reads a pending register, decode stalls and a bubble goes into execute.
//
// Decode handshake: iw_id_valid is the offer from decode. or_stall acts as
// the inverse of ready. The instruction issues (is consumed) in exactly the
// cycles where iw_id_valid && !or_stall && !iw_flush. A stalled instruction
// must be held unchanged in ID.
//
// Build option:
//   LOAD_HAZARD_AR_EN  adds AR scoreboard, AR hazard term and AR issue logic.
//                      When it is undefined, the AR inputs are ignored.
//
// Ports:
//   iw_clk, iw_rst          clock, synchronous active-high reset
//   iw_id_valid             decode holds a valid instruction
//   iw_id_src_gp(_re)       GP source index / read enable
//   iw_id_tgt_gp(_re)       GP target index / read as operand enable
//   iw_id_ld_gp_we          load writes GP iw_id_tgt_gp
//   iw_id_src_ar(_re)       AR source index / read enable
//   iw_id_tgt_ar            AR target index
//   iw_id_ld_ar_we          load writes AR iw_id_tgt_ar
//   iw_flush                pipeline flush, squashes in-flight loads
//   or_stall, or_bubble     hold IF/ID and inject NOP into ID/EX (combinational)
//   or_busy                 any scoreboard entry nonzero
//   or_stall_cnt            saturating count of stalled cycles
module load_hazard_ctrl #(
    parameter int GP_W     = 4,
    parameter int AR_W     = 2,
    parameter int LOAD_LAT = 2
) (
    input  logic            iw_clk,
    input  logic            iw_rst,
    input  logic            iw_id_valid,
    input  logic [GP_W-1:0] iw_id_src_gp,
    input  logic            iw_id_src_gp_re,
    input  logic [GP_W-1:0] iw_id_tgt_gp,
    input  logic            iw_id_tgt_gp_re,
    input  logic            iw_id_ld_gp_we,
    input  logic [AR_W-1:0] iw_id_src_ar,
    input  logic            iw_id_src_ar_re,
    input  logic [AR_W-1:0] iw_id_tgt_ar,
    input  logic            iw_id_ld_ar_we,
    input  logic            iw_flush,
    output logic            or_stall,
    output logic            or_bubble,
    output logic            or_busy,
    output logic [15:0]     or_stall_cnt
);

    localparam int         GP_N = 1 << GP_W;
    localparam logic [2:0] LAT  = 3'(LOAD_LAT);

    logic [2:0] gp_cnt     [GP_N];
    logic [2:0] gp_cnt_nxt [GP_N];
    logic       gp_haz;
    logic       ar_haz;
    logic       gp_any;
    logic       ar_any;
    logic       hazard;
    logic       issue;

    // The target index doubles as a second read port (e.g. store data).
    assign gp_haz = (iw_id_src_gp_re && (gp_cnt[iw_id_src_gp] != 3'd0)) ||
                    (iw_id_tgt_gp_re && (gp_cnt[iw_id_tgt_gp] != 3'd0));

    // Flush cancels the stall in the same cycle: the stalled instruction is
    // being squashed anyway.
    assign hazard = iw_id_valid && !iw_flush && (gp_haz || ar_haz);
    assign issue  = iw_id_valid && !iw_flush && !hazard;

    assign or_stall  = hazard;
    assign or_bubble = hazard;

    // Reload beats decrement, flush beats everything. Counters keep draining
    // while stalled because the stages behind decode keep moving.
    always_comb begin
        for (int i = 0; i < GP_N; i++) begin
            gp_cnt_nxt[i] = (gp_cnt[i] != 3'd0) ? gp_cnt[i] - 3'd1 : 3'd0;
            if (issue && iw_id_ld_gp_we && (iw_id_tgt_gp == GP_W'(i)))
                gp_cnt_nxt[i] = LAT;
            if (iw_flush)
                gp_cnt_nxt[i] = 3'd0;
        end
    end

    always_ff @(posedge iw_clk) begin
        for (int i = 0; i < GP_N; i++) begin
            if (iw_rst) gp_cnt[i] <= 3'd0;
            else        gp_cnt[i] <= gp_cnt_nxt[i];
        end
    end

    always_comb begin
        gp_any = 1'b0;
        for (int i = 0; i < GP_N; i++)
            gp_any = gp_any | (|gp_cnt[i]);
    end

`ifdef LOAD_HAZARD_AR_EN
    localparam int AR_N = 1 << AR_W;

    logic [2:0] ar_cnt     [AR_N];
    logic [2:0] ar_cnt_nxt [AR_N];

    assign ar_haz = iw_id_src_ar_re && (ar_cnt[iw_id_src_ar] != 3'd0);

    always_comb begin
        for (int i = 0; i < AR_N; i++) begin
            ar_cnt_nxt[i] = (ar_cnt[i] != 3'd0) ? ar_cnt[i] - 3'd1 : 3'd0;
            if (issue && iw_id_ld_ar_we && (iw_id_tgt_ar == AR_W'(i)))
                ar_cnt_nxt[i] = LAT;
            if (iw_flush)
                ar_cnt_nxt[i] = 3'd0;
        end
    end

    always_ff @(posedge iw_clk) begin
        for (int i = 0; i < AR_N; i++) begin
            if (iw_rst) ar_cnt[i] <= 3'd0;
            else        ar_cnt[i] <= ar_cnt_nxt[i];
        end
    end

    always_comb begin
        ar_any = 1'b0;
        for (int i = 0; i < AR_N; i++)
            ar_any = ar_any | (|ar_cnt[i]);
    end
`else
    logic unused_ar;
    assign unused_ar = ^{iw_id_src_ar, iw_id_src_ar_re, iw_id_tgt_ar, iw_id_ld_ar_we};
    assign ar_haz    = 1'b0;
    assign ar_any    = 1'b0;
`endif

    // Taken straight from the counter registers, so it follows them by one
    // edge and never depends on the current decode inputs.
    assign or_busy = gp_any | ar_any;

    always_ff @(posedge iw_clk) begin
        if (iw_rst)
            or_stall_cnt <= 16'd0;
        else if (hazard && (or_stall_cnt != 16'hFFFF))
            or_stall_cnt <= or_stall_cnt + 16'd1;
    end

endmodule
